// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: D has priority,
// a streak guard bounds I starvation, and read responses return tagged one cycle later.
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_wen,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          rv_q, rv_d;
  logic          tag_q, tag_d;       // 1 = response belongs to D
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] ihold_q, ihold_d;
  logic [DW-1:0] dhold_q, dhold_d;
  logic          guard_trip;

  // Grant and memory drive; requests are ignored while the memory image loads
  always_comb begin
    guard_trip = (MAX_D_STREAK != 0) && (streak_q == STREAK_MAX) && i_req;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    if (!rst) begin
      if (d_req && !guard_trip) d_gnt = 1'b1;
      else if (i_req)           i_gnt = 1'b1;
      else if (d_req)           d_gnt = 1'b1;
    end
    m_addr  = addr_q;
    m_wdata = wdata_q;
    m_wen   = 1'b0;
    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wen   = d_we;
    end else if (i_gnt) begin
      m_addr = i_addr;
    end
    addr_d  = m_addr;
    wdata_d = m_wdata;
  end

  // Response steering: rvalid is suppressed during reset so a pending read is dropped
  always_comb begin
    i_rvalid = rv_q & ~tag_q & ~rst;
    d_rvalid = rv_q &  tag_q & ~rst;
    i_rdata  = i_rvalid ? m_rdata : ihold_q;
    d_rdata  = d_rvalid ? m_rdata : dhold_q;
    ihold_d  = i_rdata;
    dhold_d  = d_rdata;
    rv_d     = i_gnt | (d_gnt & ~d_we);
    tag_d    = d_gnt;
  end

  always_comb begin
    streak_d = streak_q;
    if (i_gnt || !i_req)                       streak_d = '0;
    else if (d_gnt && streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      rv_q     <= 1'b0;
      tag_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ihold_q  <= '0;
      dhold_q  <= '0;
    end else begin
      streak_q <= streak_d;
      rv_q     <= rv_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ihold_q  <= ihold_d;
      dhold_q  <= dhold_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, streak sequences and random
// traffic, all checked against a grant/shadow-memory reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_wen;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [15:0] m_addr;

  logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0, m_wen0;
  logic [31:0] i_rdata0, d_rdata0, m_wdata0;
  logic [31:0] m_rdata0 = 32'h0;
  logic [15:0] m_addr0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata));

  mem_arbiter #(.AW(16), .DW(32), .MAX_D_STREAK(0)) dut0 (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt0),
    .i_rvalid(i_rvalid0), .i_rdata(i_rdata0), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt0), .d_rvalid(d_rvalid0),
    .d_rdata(d_rdata0), .m_wen(m_wen0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(m_rdata0));

  // Synchronous memory: address registered at posedge, read-first data next cycle
  logic [31:0] mem    [0:65535];
  logic [31:0] shadow [0:65535];
  always @(posedge clk) begin
    m_rdata <= mem[m_addr];
    if (m_wen === 1'b1) mem[m_addr] <= m_wdata;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          streak;
  bit          pv, pside, known, prev_rst;
  logic [31:0] pdata, ihold, dhold, lwdata;
  logic [15:0] laddr;

  typedef struct packed {
    logic        rst, ireq;
    logic [15:0] iaddr;
    logic        dreq, dwe;
    logic [15:0] daddr;
    logic [31:0] dwdata;
    logic        eig, edg, ewen, eirv, edrv;
    logic [31:0] erdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic ir, input logic [15:0] ia,
                               input logic dr, input logic dw, input logic [15:0] da,
                               input logic [31:0] dd, input logic eig, input logic edg,
                               input logic ewen, input logic eirv, input logic edrv,
                               input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da;
    v.dwdata = dd; v.eig = eig; v.edg = edg; v.ewen = ewen; v.eirv = eirv;
    v.edrv = edrv; v.erdata = erd;
    return v;
  endfunction

  // Apply one cycle of inputs, check against the model, then advance the model past the posedge
  task automatic step(input vec_t v, input bit use_tbl, output bit gi, output bit gd);
    bit          guard, ei, ed, eirv, edrv;
    logic [15:0] eaddr;
    logic [31:0] eird, edrd;
    @(negedge clk);
    rst = v.rst; i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    #1;
    guard = (streak == 4) && v.ireq;
    ed    = !v.rst && v.dreq && !guard;
    ei    = !v.rst && !ed && v.ireq;
    eaddr = ed ? v.daddr : (ei ? v.iaddr : laddr);
    eirv  = !v.rst && pv && !pside;
    edrv  = !v.rst && pv && pside;
    eird  = eirv ? pdata : ihold;
    edrd  = edrv ? pdata : dhold;

    chk("i_gnt", i_gnt, ei);
    chk("d_gnt", d_gnt, ed);
    chk("m_wen", m_wen, ed && v.dwe);
    chk("i_rvalid", i_rvalid, eirv);
    chk("d_rvalid", d_rvalid, edrv);
    if (v.rst) begin
      chk("gnt0_rst", {i_gnt0, d_gnt0}, 2'b00);
    end else begin
      chk("d_gnt_strict", d_gnt0, v.dreq);
      chk("i_gnt_strict", i_gnt0, v.ireq && !v.dreq);
    end
    if (known) begin
      chk("m_addr", m_addr, eaddr);
      chk("i_rdata", i_rdata, eird);
      chk("d_rdata", d_rdata, edrd);
      if (ed) chk("m_wdata", m_wdata, v.dwdata);
      if (v.rst && prev_rst) chk("m_wdata_rst", m_wdata, 32'h0);
    end
    if (use_tbl) begin
      chk("tbl_i_gnt", i_gnt, v.eig);
      chk("tbl_d_gnt", d_gnt, v.edg);
      chk("tbl_m_wen", m_wen, v.ewen);
      chk("tbl_i_rvalid", i_rvalid, v.eirv);
      chk("tbl_d_rvalid", d_rvalid, v.edrv);
      if (v.eirv) chk("tbl_i_rdata", i_rdata, v.erdata);
      if (v.edrv) chk("tbl_d_rdata", d_rdata, v.erdata);
    end

    if (v.rst) begin
      streak = 0; pv = 0; ihold = 0; dhold = 0; laddr = 0; lwdata = 0; known = 1;
    end else begin
      if (eirv) ihold = pdata;
      if (edrv) dhold = pdata;
      pv = 0;
      if (ei) begin
        pv = 1; pside = 0; pdata = shadow[v.iaddr];
      end
      if (ed) begin
        if (v.dwe) shadow[v.daddr] = v.dwdata;
        else begin pv = 1; pside = 1; pdata = shadow[v.daddr]; end
        lwdata = v.dwdata;
      end
      laddr = eaddr;
      if (ei || !v.ireq)          streak = 0;
      else if (ed && streak < 4)  streak = streak + 1;
    end
    prev_rst = v.rst;
    gi = ei;
    gd = ed;
  endtask

  vec_t tbl [18];

  initial begin
    bit gi, gd, ip, dp, idle_i;
    int ni, nd, ni0, nd0;
    vec_t v;
    logic [15:0] ia, da;

    for (int a = 0; a < 65536; a++) begin
      mem[a]    = 32'h5A5A_0000 | a;
      shadow[a] = 32'h5A5A_0000 | a;
    end
    mem[16'h0010] = 32'hDEADBEEF; shadow[16'h0010] = 32'hDEADBEEF;
    mem[16'h0300] = 32'h1;        shadow[16'h0300] = 32'h1;
    streak = 0; pv = 0; pside = 0; known = 0; prev_rst = 0;
    pdata = 0; ihold = 0; dhold = 0; laddr = 0; lwdata = 0;
    rst = 1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;

    //             rst ir ia        dr dw da        wdata        ig dg wn irv drv rdata
    tbl[0]  = mkv(1, 1, 16'h0010, 1, 1, 16'h0200, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 1, 16'h0010, 1, 1, 16'h0200, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 1, 16'h0010, 1, 0, 16'h0200, 32'h0,         0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,         1, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 1, 0, 32'hDEADBEEF);
    tbl[5]  = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 16'h0000, 1, 1, 16'h0200, 32'h12345678,  0, 1, 1, 0, 0, 0);
    tbl[7]  = mkv(0, 0, 16'h0000, 1, 0, 16'h0200, 32'h0,         0, 1, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 0, 1, 32'h12345678);
    tbl[9]  = mkv(0, 0, 16'h0000, 1, 0, 16'h0300, 32'h0,         0, 1, 0, 0, 0, 0);
    tbl[10] = mkv(0, 0, 16'h0000, 1, 1, 16'h0300, 32'h2,         0, 1, 1, 0, 1, 32'h1);
    tbl[11] = mkv(0, 0, 16'h0000, 1, 0, 16'h0300, 32'h0,         0, 1, 0, 0, 0, 0);
    tbl[12] = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 0, 1, 32'h2);
    tbl[13] = mkv(0, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,         1, 0, 0, 0, 0, 0);
    tbl[14] = mkv(1, 1, 16'h0010, 1, 1, 16'h0300, 32'h9,         0, 0, 0, 0, 0, 0);
    tbl[15] = mkv(1, 1, 16'h0010, 1, 1, 16'h0300, 32'h9,         0, 0, 0, 0, 0, 0);
    tbl[16] = mkv(0, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,         1, 0, 0, 0, 0, 0);
    tbl[17] = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,         0, 0, 0, 1, 0, 32'hDEADBEEF);
    for (int k = 0; k < 18; k++) step(tbl[k], 1'b1, gi, gd);

    // Both sides streaming reads: expect D,D,D,D,I from the guarded arbiter, all D from the strict one
    ia = 16'h1000; da = 16'h2000; ni0 = 0; nd0 = 0;
    for (int k = 0; k < 15; k++) begin
      v = '0; v.ireq = 1; v.iaddr = ia; v.dreq = 1; v.daddr = da;
      step(v, 1'b0, gi, gd);
      chk("streak_pattern_i", i_gnt, (k % 5) == 4);
      if (k < 10) begin
        ni0 += int'(i_gnt0);
        nd0 += int'(d_gnt0);
      end
      if (gi) ia++;
      if (gd) da++;
    end
    chk("strict_d_count", nd0, 10);
    chk("strict_i_count", ni0, 0);
    v = '0; v.dreq = 1; v.daddr = da;
    step(v, 1'b0, gi, gd);
    v = '0; v.ireq = 1; v.iaddr = ia; v.dreq = 1; v.daddr = da + 16'd1;
    step(v, 1'b0, gi, gd);
    chk("strict_after_drop", d_gnt0, 1'b1);

    // Random traffic with hold-until-granted requesters
    ip = 0; dp = 0; ni = 0; nd = 0; v = '0;
    for (int c = 0; c < 600; c++) begin
      idle_i = 0;
      if (!ip) begin
        if ($urandom_range(0, 2) != 0) begin
          ip = 1; v.iaddr = 16'h0400 + 16'($urandom_range(0, 15));
        end else idle_i = 1;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; v.daddr = 16'h0400 + 16'($urandom_range(0, 15));
        v.dwe = 1'($urandom_range(0, 1)); v.dwdata = $urandom;
      end
      v.ireq = ip && !idle_i;
      v.dreq = dp;
      v.rst  = ($urandom_range(0, 49) == 0);
      step(v, 1'b0, gi, gd);
      if (gi) begin ip = 0; ni++; end
      if (gd) begin dp = 0; nd++; end
    end
    chk("random_saw_i", ni > 50, 1'b1);
    chk("random_saw_d", nd > 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, 64K-word memory between the instruction-fetch requester (I) and the load/store requester (D) of the MIPS-like pipeline.
- The memory registers its address at posedge clk and returns read data one cycle later. A write completes at the posedge where its write enable is sampled high.
- The arbiter issues at most one access per cycle and gives D priority. A streak limit bounds how long D can starve I.
- Read responses come back tagged to the requester that issued them.

Parameters:
AW, 16, address width; matches the memory address bus.
DW, 32, data width; matches the memory data bus.
MAX_D_STREAK, 4, max consecutive D grants while i_req is pending; 0 = strict D priority, no guard.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_req  in  1  instruction read request; held until granted
i_addr  in  AW  instruction address
i_gnt  out  1  I access issued this cycle
i_rvalid  out  1  i_rdata carries the I read result this cycle
i_rdata  out  DW  I read data; holds its last value otherwise
d_req  in  1  data request; held until granted
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_gnt  out  1  D access issued this cycle
d_rvalid  out  1  d_rdata carries the D read result this cycle
d_rdata  out  DW  D read data; holds its last value otherwise
m_wen  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data (valid the cycle after the address is sampled)

Behaviour:
- Reset (rst=1 at posedge):
  - i_gnt, d_gnt, m_wen, i_rvalid, d_rvalid = 0.
  - m_addr = 0, m_wdata = 0.
  - Read-data hold registers, streak counter and response tag cleared.
  - Requests are ignored for the whole reset period; the memory is loading its image then.
  - Reset mid-operation discards any pending response: no rvalid the cycle after reset.
- Grant (combinational, same cycle as request):
  - If d_req and not guard_trip: d_gnt=1.
  - Else if i_req: i_gnt=1.
  - Else if d_req (guard tripped but i_req low): d_gnt=1.
  - guard_trip = (MAX_D_STREAK != 0) and (streak == MAX_D_STREAK) and i_req.
  - At most one gnt is high per cycle.
- Handshake:
  - A request is consumed at the posedge where req & gnt are both 1.
  - The requester changes addr/data/we only after a grant.
  - An ungranted request is re-arbitrated every cycle.
- Memory drive:
  - D granted: m_addr = d_addr, m_wdata = d_wdata, m_wen = d_we.
  - I granted: m_addr = i_addr, m_wen = 0.
  - Idle: m_addr holds the last issued address, m_wen = 0.
- Response pipeline:
  - A one-bit valid plus a one-bit tag register captures each granted read (I read, or D read with d_we=0).
  - The cycle after such a grant, the tagged side's rvalid = 1 and its rdata = m_rdata.
  - At the end of that cycle, the tagged side's hold register captures m_rdata; rdata outputs the hold register when rvalid = 0.
  - Writes produce no rvalid.
  - Back-to-back reads return back-to-back, one per cycle, in issue order.
- Streak counter (width clog2(MAX_D_STREAK+1)):
  - Increments on a D grant while i_req = 1, saturating at MAX_D_STREAK.
  - Clears on an I grant, or on any cycle where i_req = 0.
- Same-address hazards:
  - D write to A at cycle N, then a read of A granted at N+1: the read returns the new data.
  - Read of A granted at N, then D write to A at N+1: the read returns the old data (rvalid at N+1 samples memory before the write edge).
- Throughput: one access per cycle, no bubbles between grants.

Test Plan:
- Reset, then i_req=1 at i_addr=0x0010 with memory[0x0010]=0xDEADBEEF → i_gnt=1 same cycle; i_rvalid=1 next cycle with i_rdata=0xDEADBEEF; i_rdata holds that value afterwards.
- d_req write (d_we=1, d_addr=0x0200, d_wdata=0x12345678) followed directly by a D read of 0x0200 → m_wen=1 only in the first cycle; d_rvalid=1 with 0x12345678 in the cycle after the read grant; i_rvalid never set.
- i_req and d_req (reads) held high continuously, MAX_D_STREAK=4 → grant pattern D,D,D,D,I repeating; each rvalid arrives on the matching side one cycle after its grant.
- MAX_D_STREAK=0, both requesting for 10 cycles → 10 D grants, 0 I grants; when i_req drops and rises again, the streak counter does not matter.
- Read of 0x0300 (old value 0x1) granted at N, D write of 0x2 to 0x0300 at N+1 → rvalid at N+1 returns 0x1; a later read returns 0x2.
- rst asserted in the cycle after a read grant → no rvalid; gnt, m_wen and hold registers at 0 throughout reset; normal grants resume on the first cycle after rst deasserts.
